// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: requester, shared-shifter and response signals of the shift arbiter.
interface shift_arbiter_if;
    logic        r0_valid, r1_valid;
    logic        r0_ready, r1_ready;
    logic [31:0] r0_A, r1_A;
    logic [4:0]  r0_B, r1_B;
    logic        r0_ctl0, r1_ctl0, r0_ctl1, r1_ctl1;
    logic [31:0] sh_A, sh_B, sh_out;
    logic        sh_ctl0, sh_ctl1;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;
    logic        busy;

    modport slave (
        input  r0_valid, r1_valid, r0_A, r1_A, r0_B, r1_B,
               r0_ctl0, r1_ctl0, r0_ctl1, r1_ctl1, sh_out, rsp_ready,
        output r0_ready, r1_ready, sh_A, sh_B, sh_ctl0, sh_ctl1,
               rsp_valid, rsp_data, rsp_id, busy
    );

    modport master (
        output r0_valid, r1_valid, r0_A, r1_A, r0_B, r1_B,
               r0_ctl0, r1_ctl0, r0_ctl1, r1_ctl1, sh_out, rsp_ready,
        input  r0_ready, r1_ready, sh_A, sh_B, sh_ctl0, sh_ctl1,
               rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one external shifter between two requesters.
module shift_arbiter (
    input logic            clk,
    input logic            reset_n,
    shift_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t      state, next;
    logic        last_grant, grant, accept, id;
    logic [31:0] op_a, res;
    logic [4:0]  op_b;
    logic        op_c0, op_c1;

    always_comb begin
        grant  = (bus.r0_valid && bus.r1_valid) ? ~last_grant : bus.r1_valid;
        accept = reset_n && state == IDLE && (bus.r0_valid || bus.r1_valid);
        next   = state == IDLE  ? (accept ? ISSUE : IDLE) :
                 state == ISSUE ? RESP : (bus.rsp_ready ? IDLE : RESP);
    end

    assign bus.r0_ready  = accept && !grant;
    assign bus.r1_ready  = accept && grant;
    assign bus.sh_A      = op_a;
    assign bus.sh_B      = {27'b0, op_b};
    assign bus.sh_ctl0   = op_c0;
    assign bus.sh_ctl1   = op_c1;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_data  = res;
    assign bus.rsp_id    = id;
    assign bus.busy      = state != IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_c0      <= 1'b0;
            op_c1      <= 1'b0;
            res        <= '0;
            id         <= 1'b0;
        end else begin
            state <= next;
            if (accept) begin
                op_a       <= grant ? bus.r1_A : bus.r0_A;
                op_b       <= grant ? bus.r1_B : bus.r0_B;
                op_c0      <= grant ? bus.r1_ctl0 : bus.r0_ctl0;
                op_c1      <= grant ? bus.r1_ctl1 : bus.r0_ctl1;
                id         <= grant;
                last_grant <= grant;
            end
            if (state == ISSUE) res <= bus.sh_out;
        end
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed checks of arbitration, latency, backpressure, boundaries and reset.
module tb_shift_arbiter;
    logic clk = 0, reset_n = 0;
    int   errors = 0, checks = 0;
    logic signed [31:0] asr;

    shift_arbiter_if bus ();
    shift_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

    always #5 clk = ~clk;

    // stand-in for the shared shifter instance
    assign asr = $signed(bus.sh_A) >>> bus.sh_B[4:0];
    assign bus.sh_out = bus.sh_ctl1 ? (bus.sh_ctl0 ? bus.sh_A >> bus.sh_B[4:0] : asr)
                                    : bus.sh_A << bus.sh_B[4:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit r, input logic [31:0] a, input logic [4:0] b,
                           input logic c0, input logic c1);
        if (r) begin
            bus.r1_A = a; bus.r1_B = b; bus.r1_ctl0 = c0; bus.r1_ctl1 = c1;
        end else begin
            bus.r0_A = a; bus.r0_B = b; bus.r0_ctl0 = c0; bus.r0_ctl1 = c1;
        end
    endtask

    // one full transaction from a lone requester starting in IDLE
    task automatic single(input string tag, input bit r, input logic [31:0] a, input logic [4:0] b,
                          input logic c0, input logic c1, input logic [31:0] exp);
        set_req(r, a, b, c0, c1);
        bus.rsp_ready = 1;
        if (r) bus.r1_valid = 1; else bus.r0_valid = 1;
        #1;
        chk({tag, "_ready"}, {bus.r1_ready, bus.r0_ready}, r ? 2'b10 : 2'b01);
        step();
        bus.r0_valid = 0; bus.r1_valid = 0;
        chk({tag, "_issue"}, {bus.busy, bus.rsp_valid, bus.r1_ready, bus.r0_ready}, 4'b1000);
        chk({tag, "_sh_b"}, bus.sh_B, {27'b0, b});
        step();
        chk({tag, "_rvalid"}, {31'b0, bus.rsp_valid}, 1);
        chk({tag, "_data"}, bus.rsp_data, exp);
        chk({tag, "_id"}, {31'b0, bus.rsp_id}, {31'b0, r});
        step();
        chk({tag, "_idle"}, {bus.busy, bus.rsp_valid}, 2'b00);
    endtask

    initial begin
        bus.r0_valid = 0; bus.r1_valid = 0; bus.rsp_ready = 0;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        #1;
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_rvalid", {31'b0, bus.rsp_valid}, 0);
        chk("rst_data", bus.rsp_data, 0);
        chk("rst_id", {31'b0, bus.rsp_id}, 0);
        chk("rst_sh_a", bus.sh_A, 0);
        bus.r0_valid = 1; #1;
        chk("rst_ready", {bus.r1_ready, bus.r0_ready}, 2'b00);
        bus.r0_valid = 0;
        #10 reset_n = 1;

        single("single", 0, 32'h8000_0000, 5'd4, 0, 1, 32'hF800_0000);

        // fresh reset so r0 wins the first contention
        #2 reset_n = 0;
        #2 reset_n = 1;
        set_req(0, 32'h1, 5'd3, 0, 0);
        set_req(1, 32'hF0, 5'd4, 1, 1);
        bus.r0_valid = 1; bus.r1_valid = 1; bus.rsp_ready = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("cont%0d_grant", i), {bus.r1_ready, bus.r0_ready}, (i % 2) ? 2'b10 : 2'b01);
            step();
            chk($sformatf("cont%0d_issue", i), {bus.r1_ready, bus.r0_ready, bus.rsp_valid}, 3'b000);
            if (i == 2) begin bus.r0_valid = 0; bus.r1_valid = 0; end
            step();
            chk($sformatf("cont%0d_data", i), bus.rsp_data, (i % 2) ? 32'hF : 32'h8);
            chk($sformatf("cont%0d_id", i), {31'b0, bus.rsp_id}, (i % 2) ? 1 : 0);
            chk($sformatf("cont%0d_resp", i), {bus.r1_ready, bus.r0_ready}, 2'b00);
            step();
        end

        // backpressure with r1 waiting; B = 0 passes A unchanged
        set_req(0, 32'h1234_5678, 5'd0, 0, 0);
        bus.r0_valid = 1; #1;
        chk("bp_r0_ready", {bus.r1_ready, bus.r0_ready}, 2'b01);
        step();
        bus.r0_valid = 0; bus.rsp_ready = 0;
        set_req(1, 32'hFFFF_FFFF, 5'd31, 1, 1);
        bus.r1_valid = 1; #1;
        chk("bp_issue_r1", {31'b0, bus.r1_ready}, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_hold", i), {bus.rsp_valid, bus.rsp_id, bus.r1_ready}, 3'b100);
            chk($sformatf("bp%0d_data", i), bus.rsp_data, 32'h1234_5678);
            step();
        end
        bus.rsp_ready = 1; #1;
        chk("bp_hs_r1", {bus.rsp_valid, bus.r1_ready}, 2'b10);
        step();
        chk("bp_idle_r1", {bus.busy, bus.r1_ready}, 2'b01);
        step();
        bus.r1_valid = 0;
        step();
        chk("lsr31_data", bus.rsp_data, 32'h0000_0001);
        chk("lsr31_id", {31'b0, bus.rsp_id}, 1);
        step();

        single("asr31", 0, 32'hFFFF_FFFF, 5'd31, 0, 1, 32'hFFFF_FFFF);
        single("lsl31", 1, 32'h1, 5'd31, 0, 0, 32'h8000_0000);

        // reset in ISSUE
        set_req(0, 32'hAAAA_5555, 5'd1, 1, 1);
        bus.r0_valid = 1;
        step();
        bus.r0_valid = 0;
        chk("mid_busy", {31'b0, bus.busy}, 1);
        #2 reset_n = 0;
        #1;
        chk("mid_rst", {bus.busy, bus.rsp_valid}, 2'b00);
        chk("mid_rst_sh_a", bus.sh_A, 0);
        set_req(1, 32'h5, 5'd1, 0, 0);
        bus.r0_valid = 1; bus.r1_valid = 1;
        #2 reset_n = 1; #1;
        chk("mid_r0_first", {bus.r1_ready, bus.r0_ready}, 2'b01);
        step();
        bus.r0_valid = 0; bus.r1_valid = 0;
        step();
        chk("mid_data", bus.rsp_data, 32'h5555_2AAA);
        chk("mid_id", {31'b0, bus.rsp_id}, 0);
        step();

        // r1 withdraws while busy; r0 still holds the last grant
        bus.r0_valid = 1;
        step();
        bus.r0_valid = 0; bus.r1_valid = 1; #1;
        chk("wd_r1_busy", {31'b0, bus.r1_ready}, 0);
        step();
        bus.r1_valid = 0;
        step();
        chk("wd_idle", {bus.busy, bus.r1_ready, bus.r0_ready}, 3'b000);
        bus.r0_valid = 1; bus.r1_valid = 1; #1;
        chk("wd_grant_r1", {bus.r1_ready, bus.r0_ready}, 2'b10);
        step();
        bus.r0_valid = 0; bus.r1_valid = 0;
        step();
        chk("wd_id", {31'b0, bus.rsp_id}, 1);
        chk("wd_data", bus.rsp_data, 32'hA);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- r0_valid / r1_valid  input  1  requester 0/1 has a shift request pending.
- r0_ready / r1_ready  output  1  requester 0/1 request accepted this cycle.
- r0_A / r1_A  input  32  operand to shift.
- r0_B / r1_B  input  5  shift amount.
- r0_ctl0 / r1_ctl0  input  1  1 = logical, 0 = arithmetic.
- r0_ctl1 / r1_ctl1  input  1  1 = right shift, 0 = left shift.
- sh_A  output  32  operand to the shared shifter instance.
- sh_B  output  32  amount to the shared shifter; bits 31:5 are always 0.
- sh_ctl0 / sh_ctl1  output  1  shifter controls, same encoding as the requester fields.
- sh_out  input  32  combinational shifter result.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  32  shift result.
- rsp_id  output  1  requester that owns rsp_data.
- busy  output  1  high whenever state is not IDLE.

Function
REQ-002 The FSM SHALL have three states: IDLE, ISSUE, RESP.
REQ-003 A request SHALL be accepted only in IDLE; r0_ready and r1_ready SHALL both be 0 in ISSUE and RESP.
REQ-004 In IDLE, rN_ready SHALL be combinational, at most one asserted, and asserted only for the granted requester whose rN_valid = 1.
REQ-005 Arbitration SHALL be round-robin:
- If only one requester is valid, it is granted.
- If both are valid, the requester not granted last time is granted.
- last_grant SHALL reset to 1, so r0 wins the first contention.
REQ-006 On an accept edge, the block SHALL:
- register the granted A, B, ctl0 and ctl1 into the operand register;
- record the owner id;
- update last_grant;
- move to ISSUE.
REQ-007 sh_A, sh_B, sh_ctl0 and sh_ctl1 SHALL be driven only from the operand register.
REQ-008 In ISSUE, the next edge SHALL capture sh_out into the result register and move to RESP.
REQ-009 In RESP, rsp_valid SHALL be 1, and rsp_data and rsp_id SHALL be held stable until rsp_ready = 1.
REQ-010 RESP with rsp_ready = 1 SHALL return the FSM to IDLE on that edge; no request SHALL be accepted on the same edge.
REQ-011 Latency SHALL be as follows:
- accept at edge k gives rsp_valid = 1 from edge k+1;
- minimum spacing between accepts is 3 cycles.
REQ-012 The operand register SHALL hold its value after ISSUE, so sh_* stay stable until the next accept.
REQ-013 A requester that drops rN_valid without being granted SHALL lose nothing and change no state.
REQ-014 B values 0 and 31 SHALL pass through unchanged; the block SHALL NOT alter the shift semantics.
REQ-015 busy SHALL equal (state != IDLE).

Reset
REQ-016 reset_n = 0 SHALL act immediately, without waiting for clk, and SHALL set:
- state = IDLE, last_grant = 1;
- operand register, result register, rsp_id = 0;
- rsp_valid = 0, busy = 0, r0_ready = r1_ready = 0.
REQ-017 Reset asserted in ISSUE or RESP SHALL abort the operation and drop the pending result.
REQ-018 After reset_n deasserts, the first accept SHALL be possible on the first clk edge.

Verification
REQ-019 Single request: r0_valid = 1, A = 0x80000000, B = 4, ctl0 = 0, ctl1 = 1 -> r0_ready = 1 for 1 cycle; rsp_valid from edge k+1; rsp_data = 0xF8000000; rsp_id = 0.
REQ-020 Contention: both requesters valid continuously, r0 A = 0x1, B = 3, left; r1 A = 0xF0, B = 4, logical right; rsp_ready = 1 -> grants alternate r0, r1, r0; results 0x8, 0xF, 0x8; every accept 3 cycles apart.
REQ-021 Backpressure: rsp_ready = 0 for 5 cycles during RESP with r1_valid = 1 -> rsp_data/rsp_id held; r1_ready = 0 throughout; r1 is accepted on the first IDLE cycle after the rsp_ready handshake.
REQ-022 Boundaries: B = 0 -> rsp_data = A; A = 0xFFFFFFFF, B = 31, logical right -> 0x00000001; same operands, arithmetic right -> 0xFFFFFFFF; A = 0x1, B = 31, left -> 0x80000000.
REQ-023 Reset mid-operation: assert reset_n = 0 between edges while in ISSUE -> rsp_valid and busy fall to 0 before the next edge; afterwards r0 wins contention first.
REQ-024 Withdrawal: r1_valid = 1 for 1 cycle while busy, then 0 -> no r1 grant; last_grant unchanged.
